median_window_ctrl: RTL and testbench
=====================================

MEDIAN_WINDOW_CTRL -- requirements
Module: median_window_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, 8, pixel width.
- IMG_W, 8, frame width in pixels, at least 3.
- IMG_H, 8, frame height in pixels, at least 3.
- PIPE_LAT, 0, median datapath latency in cycles; 0 means combinational.

REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin frame.
- pix_in  in  DATA_W  input pixel, raster order.
- pix_valid  in  1  input handshake.
- pix_ready  out  1  input handshake.
- win_a..win_i  out  DATA_W each  3x3 window to the median datapath.
- win_valid  out  1  window qualifier.
- med_in  in  DATA_W  median returned by the datapath.
- med_out  out  DATA_W  result.
- med_valid  out  1  result handshake.
- med_ready  in  1  result handshake.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle completion pulse.

Function
REQ-003 An input transfer SHALL occur on a rising clk edge where pix_valid and pix_ready are both 1; an output transfer SHALL occur where med_valid and med_ready are both 1.
REQ-004 The FSM SHALL have four states with these transitions:
- IDLE -> ACCEPT on start.
- ACCEPT -> DRAIN when pixel IMG_W*IMG_H-1 is accepted.
- DRAIN -> DONE when nothing is in flight and the result buffer is empty.
- DONE -> IDLE after one cycle.
REQ-005 start SHALL be ignored outside IDLE; pix_valid SHALL be ignored outside ACCEPT.
REQ-006 Two line buffers of IMG_W entries SHALL hold the two previous rows; row and column counters SHALL wrap at IMG_W-1 and IMG_H-1.
REQ-007 An accepted pixel at row>=2 and col>=2 SHALL complete a window; border pixels SHALL produce no window and no output.
REQ-008 The window SHALL be row-major, oldest row first: win_a = (r-2,c-2), win_e = (r-1,c-1), win_i = current pixel.
REQ-009 The window SHALL be registered: win_valid is high exactly one cycle, in the cycle after the completing transfer.
REQ-010 A PIPE_LAT-deep valid shift register SHALL track windows in flight; med_in SHALL be captured into the result FIFO in the cycle where the delayed win_valid is high.
REQ-011 The result FIFO depth SHALL be PIPE_LAT+2.
REQ-012 A credit counter SHALL hold FIFO free slots minus windows in flight. It SHALL decrement on each completing transfer and increment on each output transfer; when both occur in the same cycle it SHALL stay unchanged.
REQ-013 pix_ready SHALL be 1 only in ACCEPT with credit > 0.
REQ-014 The FIFO SHALL never overflow or underflow under any med_ready pattern.
REQ-015 Results SHALL leave in raster order, and med_out SHALL hold steady while med_valid=1 and med_ready=0.
REQ-016 The earliest med_valid SHALL occur PIPE_LAT+2 cycles after the completing transfer.
REQ-017 busy SHALL be 1 in ACCEPT and DRAIN; frame_done SHALL be 1 only in DONE.
REQ-018 A frame SHALL produce exactly (IMG_W-2)*(IMG_H-2) results.

Reset
REQ-019 While rst=1 at a rising edge, the block SHALL enter IDLE and clear counters, credits (credit = PIPE_LAT+2), FIFO pointers and the in-flight register.
REQ-020 The outputs pix_ready, win_a..win_i, win_valid, med_out, med_valid, busy and frame_done SHALL be 0 after reset.
REQ-021 Reset mid-frame SHALL discard all pending pixels and results, and the next start SHALL process a fresh frame correctly.
REQ-022 Line-buffer contents need not be cleared by reset.

Structure
REQ-023 A shared package median_pkg SHALL hold the FSM state enum (IDLE, ACCEPT, DRAIN, DONE) and the default DATA_W.
REQ-024 The result FIFO SHALL be a sub-module named median_res_fifo (depth, width parameters; full/empty flags).
REQ-025 The median datapath itself SHALL stay outside this block.

Verification
REQ-026 Reset check: assert rst for 2 cycles, then check all outputs are 0 and start=0 keeps pix_ready=0 and busy=0.
REQ-027 3x3 frame (IMG_W=IMG_H=3, PIPE_LAT=0) with pixels 49,9,85,171,51,1,127,109,42 SHALL give:
- win_a..win_i = those values in order;
- exactly one result, med_out=51;
- frame_done high for one cycle after DRAIN.
REQ-028 8x8 ramp with pix=8*r+c and med_ready=1 SHALL give 36 results, each equal to the window centre, in raster order.
REQ-029 Backpressure with PIPE_LAT=3 and med_ready=0: pix_ready SHALL drop after 5 completed windows. Releasing med_ready SHALL deliver all 36 results with no loss, duplication or reorder.
REQ-030 rst asserted after 20 accepted pixels SHALL clear the block; a new start followed by a full ramp frame SHALL give the correct 36 results.
REQ-031 start pulsed during ACCEPT and pix_valid held in IDLE SHALL be ignored: state unchanged and no pixel accepted.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types and defaults for the 3x3 median window controller.
package median_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        DRAIN,
        DONE
    } state_e;

    localparam int unsigned DEFAULT_DATA_W = 8;

endpackage

// File: rtl/median_res_fifo.sv
// Result FIFO for median values; read data is forced to zero while empty.
module median_res_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/median_window_ctrl.sv
// Streams a raster frame through two line buffers, presents 3x3 windows to an external
// median datapath and returns its results through a credit-protected FIFO.
module median_window_ctrl
    import median_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned IMG_W    = 8,
    parameter int unsigned IMG_H    = 8,
    parameter int unsigned PIPE_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [DATA_W-1:0] win_a,
    output logic [DATA_W-1:0] win_b,
    output logic [DATA_W-1:0] win_c,
    output logic [DATA_W-1:0] win_d,
    output logic [DATA_W-1:0] win_e,
    output logic [DATA_W-1:0] win_f,
    output logic [DATA_W-1:0] win_g,
    output logic [DATA_W-1:0] win_h,
    output logic [DATA_W-1:0] win_i,
    output logic              win_valid,
    input  logic [DATA_W-1:0] med_in,
    output logic [DATA_W-1:0] med_out,
    output logic              med_valid,
    input  logic              med_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned DEPTH = PIPE_LAT + 2;
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned CRD_W = $clog2(DEPTH + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [CRD_W-1:0] CRD_INIT = CRD_W'(DEPTH);

    state_e            r_state;
    state_e            w_state_next;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [CRD_W-1:0]  r_credit;
    logic [CRD_W-1:0]  w_credit_next;
    logic [DATA_W-1:0] r_lb0 [IMG_W];
    logic [DATA_W-1:0] r_lb1 [IMG_W];
    logic [DATA_W-1:0] r_top1, r_top2, r_mid1, r_mid2, r_bot1, r_bot2;
    logic [DATA_W-1:0] r_win [9];
    logic              r_win_valid;
    logic [DATA_W-1:0] w_top;
    logic [DATA_W-1:0] w_mid;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_complete;
    logic              w_last_pix;
    logic              w_capture;
    logic              w_inflight;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    assign pix_ready  = (r_state == ACCEPT) && (r_credit != '0);
    assign w_in_xfer  = pix_valid && pix_ready;
    assign w_out_xfer = med_valid && med_ready;
    assign w_complete = w_in_xfer && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
    assign w_last_pix = w_in_xfer && (r_row == ROW_LAST) && (r_col == COL_LAST);
    // lb1 holds row r-2 and lb0 row r-1 at the current column
    assign w_top      = r_lb1[r_col];
    assign w_mid      = r_lb0[r_col];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_next = ACCEPT;
            ACCEPT:  if (w_last_pix) w_state_next = DRAIN;
            DRAIN:   if (!w_inflight && w_fifo_empty) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Credit = free FIFO slots minus windows still in the datapath
    always_comb begin
        w_credit_next = r_credit;
        if (w_complete && !w_out_xfer) begin
            w_credit_next = r_credit - CRD_W'(1);
        end else if (!w_complete && w_out_xfer) begin
            w_credit_next = r_credit + CRD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_credit    <= CRD_INIT;
            r_win_valid <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
        end else begin
            r_credit    <= w_credit_next;
            r_win_valid <= w_complete;
            if (r_state == IDLE) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_in_xfer) begin
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
            if (w_complete) begin
                r_win[0] <= r_top2;
                r_win[1] <= r_top1;
                r_win[2] <= w_top;
                r_win[3] <= r_mid2;
                r_win[4] <= r_mid1;
                r_win[5] <= w_mid;
                r_win[6] <= r_bot2;
                r_win[7] <= r_bot1;
                r_win[8] <= pix_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_lb1[r_col] <= w_mid;
            r_lb0[r_col] <= pix_in;
            r_top2       <= r_top1;
            r_top1       <= w_top;
            r_mid2       <= r_mid1;
            r_mid1       <= w_mid;
            r_bot2       <= r_bot1;
            r_bot1       <= pix_in;
        end
    end

    generate
        if (PIPE_LAT == 0) begin : g_no_pipe
            assign w_capture  = r_win_valid;
            assign w_inflight = r_win_valid;
        end else begin : g_pipe
            logic [PIPE_LAT-1:0] r_vpipe;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= (r_vpipe << 1) | PIPE_LAT'(r_win_valid);
                end
            end
            assign w_capture  = r_vpipe[PIPE_LAT-1];
            assign w_inflight = r_win_valid || (r_vpipe != '0);
        end
    endgenerate

    median_res_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_res_fifo (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (w_capture),
        .i_wr_data (med_in),
        .i_rd_en   (med_ready),
        .o_rd_data (med_out),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // Credits make a capture into a full FIFO impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) w_capture |-> !w_fifo_full);

    assign med_valid  = !w_fifo_empty;
    assign win_a      = r_win[0];
    assign win_b      = r_win[1];
    assign win_c      = r_win[2];
    assign win_d      = r_win[3];
    assign win_e      = r_win[4];
    assign win_f      = r_win[5];
    assign win_g      = r_win[6];
    assign win_h      = r_win[7];
    assign win_i      = r_win[8];
    assign win_valid  = r_win_valid;
    assign busy       = (r_state == ACCEPT) || (r_state == DRAIN);
    assign frame_done = (r_state == DONE);

endmodule

// File: tb/tb_median_window_ctrl.sv
// Bench: 8x8/PIPE_LAT=3 instance checked by a result scoreboard fed from a frame-level
// median model, plus a 3x3 combinational-datapath instance with a fixed frame.
module tb_median_window_ctrl;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int LAT  = 3;
    localparam int NPIX = W * H;
    localparam int NRES = (W - 2) * (H - 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, pix_valid, pix_ready, win_valid, med_valid, med_ready, busy, frame_done;
    logic [7:0] pix_in, med_in, med_out;
    logic [7:0] win_a, win_b, win_c, win_d, win_e, win_f, win_g, win_h, win_i;

    logic       s_start, s_pix_valid, s_pix_ready, s_win_valid, s_med_valid, s_med_ready;
    logic       s_busy, s_frame_done;
    logic [7:0] s_pix_in, s_med_in, s_med_out;
    logic [7:0] s_win [9];

    median_window_ctrl #(
        .DATA_W (8), .IMG_W (W), .IMG_H (H), .PIPE_LAT (LAT)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .pix_in (pix_in), .pix_valid (pix_valid),
        .pix_ready (pix_ready), .win_a (win_a), .win_b (win_b), .win_c (win_c),
        .win_d (win_d), .win_e (win_e), .win_f (win_f), .win_g (win_g), .win_h (win_h),
        .win_i (win_i), .win_valid (win_valid), .med_in (med_in), .med_out (med_out),
        .med_valid (med_valid), .med_ready (med_ready), .busy (busy), .frame_done (frame_done)
    );

    median_window_ctrl #(
        .DATA_W (8), .IMG_W (3), .IMG_H (3), .PIPE_LAT (0)
    ) dut_s (
        .clk (clk), .rst (rst), .start (s_start), .pix_in (s_pix_in),
        .pix_valid (s_pix_valid), .pix_ready (s_pix_ready), .win_a (s_win[0]),
        .win_b (s_win[1]), .win_c (s_win[2]), .win_d (s_win[3]), .win_e (s_win[4]),
        .win_f (s_win[5]), .win_g (s_win[6]), .win_h (s_win[7]), .win_i (s_win[8]),
        .win_valid (s_win_valid), .med_in (s_med_in), .med_out (s_med_out),
        .med_valid (s_med_valid), .med_ready (s_med_ready), .busy (s_busy),
        .frame_done (s_frame_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_res   = 0;
    int rdy_mode = 1;
    int start_at = -1;
    int exp_q[$];
    int frame [NPIX];

    task automatic check(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    function automatic int median_of(input int v [9]);
        int a [9];
        int t;
        a = v;
        for (int i = 1; i < 9; i++) begin
            for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
                t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
        end
        return a[4];
    endfunction

    function automatic logic [7:0] median_pk(input logic [71:0] p);
        int v [9];
        for (int k = 0; k < 9; k++) v[k] = int'(p[k*8 +: 8]);
        return 8'(median_of(v));
    endfunction

    // Stand-in median datapaths: LAT-cycle pipeline for the main instance, combinational for 3x3
    logic [7:0] dp_pipe [LAT];
    always @(posedge clk) begin
        dp_pipe[0] <= median_pk({win_a, win_b, win_c, win_d, win_e, win_f, win_g, win_h, win_i});
        for (int k = 1; k < LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
    end
    assign med_in   = dp_pipe[LAT-1];
    assign s_med_in = median_pk({s_win[0], s_win[1], s_win[2], s_win[3], s_win[4],
                                 s_win[5], s_win[6], s_win[7], s_win[8]});

    initial begin
        med_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       med_ready = 1'b0;
                1:       med_ready = 1'b1;
                default: med_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Scoreboard monitor for the main instance
    initial begin
        bit         prev_stall;
        logic [7:0] prev_out;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", med_valid, 1);
                    check("hold_data", med_out, prev_out);
                end
                if (med_valid && med_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_result: got %0d, required no result", med_out);
                    end else begin
                        check("result", med_out, exp_q.pop_front());
                    end
                    n_res++;
                end
                prev_stall = med_valid && !med_ready;
                prev_out   = med_out;
            end
        end
    end

    // Observer for the 3x3 instance
    int         s_cyc = 0, s_winc = 0, s_resc = 0, s_res = 0, s_done_cnt = 0;
    int         s_win_cyc = -1, s_med_cyc = -1;
    logic [7:0] s_wcap [9];
    initial begin
        forever begin
            @(negedge clk);
            s_cyc++;
            if (!rst) begin
                if (s_win_valid) begin
                    s_winc++;
                    s_win_cyc = s_cyc;
                    for (int k = 0; k < 9; k++) s_wcap[k] = s_win[k];
                end
                if (s_med_valid && s_med_cyc < 0) s_med_cyc = s_cyc;
                if (s_med_valid && s_med_ready) begin
                    s_resc++;
                    s_res = int'(s_med_out);
                end
                if (s_frame_done) s_done_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    // kind 0: ramp 8r+c, expected result is the window centre; kind 1: random, true median
    task automatic make_frame(input int kind);
        int v [9];
        for (int i = 0; i < NPIX; i++) frame[i] = (kind == 0) ? i : int'($urandom_range(0, 255));
        exp_q.delete();
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                if (kind == 0) begin
                    exp_q.push_back(frame[(r-1)*W + c-1]);
                end else begin
                    for (int k = 0; k < 9; k++) v[k] = frame[(r-2+k/3)*W + c-2+k%3];
                    exp_q.push_back(median_of(v));
                end
            end
        end
        n_res = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        int cyc;
        bit acc;
        for (int i = lo; i <= hi; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            pix_in    = 8'(frame[i]);
            pix_valid = 1'b1;
            if (i == start_at) start = 1'b1;
            cyc = 0;
            acc = 1'b0;
            while (!acc && cyc < 1000) begin
                @(negedge clk);
                acc = pix_ready;
                cyc++;
            end
            @(posedge clk); #1;
            pix_valid = 1'b0;
            start     = 1'b0;
            if (!acc) begin
                n_tests++;
                n_fail++;
                $display("FAIL pixel_accept: got no accept of pixel %0d, required accept", i);
                return;
            end
        end
    endtask

    task automatic finish_frame(input string nm);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            seen = frame_done;
            cyc++;
        end
        check({nm, "_done_seen"}, seen, 1);
        @(negedge clk);
        check({nm, "_done_pulse"}, frame_done, 0);
        check({nm, "_busy_idle"}, busy, 0);
        check({nm, "_count"}, n_res, NRES);
        check({nm, "_leftover"}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int s_vals [9];
        int cyc;
        bit acc;
        s_vals = '{49, 9, 85, 171, 51, 1, 127, 109, 42};
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0;
        s_start = 1'b0; s_pix_valid = 1'b0; s_pix_in = '0; s_med_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_win", int'(|{win_a, win_b, win_c, win_d, win_e, win_f, win_g, win_h, win_i}), 0);
        check("rst_win_valid", win_valid, 0);
        check("rst_med_out", med_out, 0);
        check("rst_med_valid", med_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_s_pix_ready", s_pix_ready, 0);
        check("rst_s_busy", s_busy, 0);

        pix_in    = 8'hAA;
        pix_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_pix_ready", pix_ready, 0);
        check("idle_busy", busy, 0);
        @(posedge clk); #1;
        pix_valid = 1'b0;

        // Fixed 3x3 frame on the combinational-datapath instance
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            s_pix_in    = 8'(s_vals[i]);
            s_pix_valid = 1'b1;
            cyc = 0;
            acc = 1'b0;
            while (!acc && cyc < 100) begin
                @(negedge clk);
                acc = s_pix_ready;
                cyc++;
            end
            @(posedge clk); #1;
            s_pix_valid = 1'b0;
            if (!acc) begin
                n_tests++;
                n_fail++;
                $display("FAIL s_pixel_accept: got no accept of pixel %0d, required accept", i);
            end
        end
        cyc = 0;
        while (s_done_cnt == 0 && cyc < 50) begin @(negedge clk); cyc++; end
        repeat (3) @(negedge clk);
        check("s_windows", s_winc, 1);
        for (int k = 0; k < 9; k++) check($sformatf("s_win_%0d", k), s_wcap[k], s_vals[k]);
        check("s_results", s_resc, 1);
        check("s_median", s_res, 51);
        check("s_latency", s_med_cyc - s_win_cyc, 1);
        check("s_done_cycles", s_done_cnt, 1);
        @(posedge clk); #1;

        // Ramp, always ready
        rdy_mode = 1;
        make_frame(0);
        do_start();
        send_range(0, NPIX - 1, 1'b0);
        finish_frame("ramp");

        // Random pixels, random ready and gaps, stray start mid-frame
        rdy_mode = 2;
        make_frame(1);
        start_at = 30;
        do_start();
        send_range(0, NPIX - 1, 1'b1);
        start_at = -1;
        finish_frame("rand");

        // Backpressure: five credits with PIPE_LAT=3
        rdy_mode = 0;
        @(posedge clk); #1;
        make_frame(0);
        do_start();
        send_range(0, 21, 1'b0);
        repeat (10) @(negedge clk);
        check("bp_ready_after4", pix_ready, 1);
        @(posedge clk); #1;
        send_range(22, 22, 1'b0);
        repeat (10) @(negedge clk);
        check("bp_ready_after5", pix_ready, 0);
        check("bp_busy", busy, 1);
        check("bp_med_valid", med_valid, 1);
        @(posedge clk); #1;
        rdy_mode = 2;
        send_range(23, NPIX - 1, 1'b1);
        finish_frame("bp");

        // Reset after 20 pixels, then a clean frame
        rdy_mode = 1;
        make_frame(0);
        do_start();
        send_range(0, 19, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_pix_ready", pix_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_med_valid", med_valid, 0);
        check("mid_rst_win_valid", win_valid, 0);
        @(posedge clk); #1;
        rdy_mode = 2;
        make_frame(0);
        do_start();
        send_range(0, NPIX - 1, 1'b1);
        finish_frame("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
